// File: rtl/sat_pkg.sv
// Shared types for the SAT trail stack: entry layout, entry kinds and FSM states.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 7
`endif

package sat_pkg;

  // Widest variable index an entry can hold; trail_stack instances use VAR_BITS <= this.
  localparam int MAX_VAR_BITS = `MAX_VARS_BITS;

  localparam logic TRAIL_DECISION = 1'b0;
  localparam logic TRAIL_FORCED   = 1'b1;

  // Fields are var/val/type; vid and typ avoid the SystemVerilog keywords.
  typedef struct packed {
    logic [MAX_VAR_BITS-1:0] vid;
    logic                    val;
    logic                    typ;
  } trail_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNWIND = 2'd1,
    DONE   = 2'd2
  } trail_state_t;

endpackage

// File: rtl/trail_mem.sv
// Trail entry storage: one synchronous write port, one combinational read port.
module trail_mem
  import sat_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  trail_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output trail_entry_t             rdata
);

  trail_entry_t mem [DEPTH];

  // Storage is deliberately not reset; occupancy is tracked by the owner.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trail_stack.sv
// Assignment trail stack with a backtrack unwinder that streams popped entries
// out for unassignment and reports the most recent decision it removed.
module trail_stack
  import sat_pkg::*;
#(
  parameter int DEPTH    = 128,
  parameter int VAR_BITS = `MAX_VARS_BITS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [VAR_BITS-1:0]        var_in,
  input  logic                       val_in,
  input  logic                       type_in,
  input  logic                       pop,
  output logic [VAR_BITS-1:0]        top_var,
  output logic                       top_val,
  output logic                       top_type,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     dec_level,
  input  logic                       backtrack,
  output logic                       busy,
  output logic                       uw_valid,
  input  logic                       uw_ready,
  output logic [VAR_BITS-1:0]        uw_var,
  output logic                       uw_val,
  output logic                       uw_type,
  output logic                       bt_done,
  output logic                       bt_found,
  output logic [VAR_BITS-1:0]        bt_var,
  output logic                       bt_val,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trail_state_t        state, state_nxt;
  logic [CW-1:0]       count_nxt, dec_nxt;
  logic                found_nxt, bval_nxt, ovf_nxt, unf_nxt;
  logic [VAR_BITS-1:0] bvar_nxt;

  logic                we;
  logic [AW-1:0]       waddr, top_addr;
  trail_entry_t        wdata, rd;
  logic                top_dec, in_dec, uw_pop;

  // Top of stack lives at count-1; wraps harmlessly when empty since outputs are masked.
  assign top_addr = count[AW-1:0] - AW'(1);

  trail_mem #(.DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (top_addr),
    .rdata (rd)
  );

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign top_var  = empty ? '0 : VAR_BITS'(rd.vid);
  assign top_val  = empty ? 1'b0 : rd.val;
  assign top_type = empty ? 1'b0 : rd.typ;

  assign top_dec  = !empty && (rd.typ == TRAIL_DECISION);
  assign in_dec   = (type_in == TRAIL_DECISION);

  assign busy     = (state != IDLE);
  assign uw_valid = (state == UNWIND) && !empty;
  assign uw_var   = top_var;
  assign uw_val   = top_val;
  assign uw_type  = top_type;
  assign uw_pop   = uw_valid && uw_ready;
  // A clear landing in DONE swallows the pulse so the consumer never sees a stale result.
  assign bt_done  = (state == DONE) && !clear;

  // Next-state, stack bookkeeping and memory write control.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    dec_nxt   = dec_level;
    found_nxt = bt_found;
    bvar_nxt  = bt_var;
    bval_nxt  = bt_val;
    ovf_nxt   = overflow;
    unf_nxt   = underflow;
    we        = 1'b0;
    waddr     = count[AW-1:0];
    wdata.vid = MAX_VAR_BITS'(var_in);
    wdata.val = val_in;
    wdata.typ = type_in;

    if (clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
      dec_nxt   = '0;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (backtrack) begin
            state_nxt = UNWIND;
            found_nxt = 1'b0;
            bvar_nxt  = '0;
            bval_nxt  = 1'b0;
          end else if (push && pop) begin
            if (!empty) begin
              // Replace the top entry in place.
              we      = 1'b1;
              waddr   = top_addr;
              dec_nxt = dec_level + CW'(in_dec) - CW'(top_dec);
            end else begin
              // Pop half underflows; the push half still lands.
              unf_nxt   = 1'b1;
              we        = 1'b1;
              count_nxt = count + CW'(1);
              dec_nxt   = dec_level + CW'(in_dec);
            end
          end else if (push) begin
            if (full) begin
              ovf_nxt = 1'b1;
            end else begin
              we        = 1'b1;
              count_nxt = count + CW'(1);
              dec_nxt   = dec_level + CW'(in_dec);
            end
          end else if (pop) begin
            if (empty) begin
              unf_nxt = 1'b1;
            end else begin
              count_nxt = count - CW'(1);
              dec_nxt   = dec_level - CW'(top_dec);
            end
          end
        end
        UNWIND: begin
          if (empty) begin
            state_nxt = DONE;
            found_nxt = 1'b0;
          end else if (uw_pop) begin
            count_nxt = count - CW'(1);
            if (top_dec) begin
              dec_nxt   = dec_level - CW'(1);
              found_nxt = 1'b1;
              bvar_nxt  = top_var;
              bval_nxt  = top_val;
              state_nxt = DONE;
            end
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      dec_level <= '0;
      bt_found  <= 1'b0;
      bt_var    <= '0;
      bt_val    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      dec_level <= dec_nxt;
      bt_found  <= found_nxt;
      bt_var    <= bvar_nxt;
      bt_val    <= bval_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_trail_stack.sv
// Bench for trail_stack: directed scenarios plus random traffic against a queue model.
module tb_trail_stack;

  localparam int DEPTH = 8;
  localparam int VB    = 7;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          push = 1'b0, pop = 1'b0, val_in = 1'b0, type_in = 1'b0;
  logic [VB-1:0] var_in = '0;
  logic          backtrack = 1'b0, uw_ready = 1'b0;

  logic [VB-1:0] top_var, uw_var, bt_var;
  logic          top_val, top_type, empty, full, busy;
  logic          uw_valid, uw_val, uw_type, bt_done, bt_found, bt_val;
  logic          overflow, underflow;
  logic [CW-1:0] count, dec_level;

  trail_stack #(.DEPTH(DEPTH), .VAR_BITS(VB)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .push(push), .var_in(var_in), .val_in(val_in), .type_in(type_in), .pop(pop),
    .top_var(top_var), .top_val(top_val), .top_type(top_type),
    .empty(empty), .full(full), .count(count), .dec_level(dec_level),
    .backtrack(backtrack), .busy(busy),
    .uw_valid(uw_valid), .uw_ready(uw_ready), .uw_var(uw_var), .uw_val(uw_val), .uw_type(uw_type),
    .bt_done(bt_done), .bt_found(bt_found), .bt_var(bt_var), .bt_val(bt_val),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  typedef struct {int v; int val; int t;} ent_t;

  ent_t q[$];
  int   ovf_m = 0, unf_m = 0;
  int   total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int n_dec();
    int n = 0;
    foreach (q[i]) if (q[i].t == 0) n++;
    return n;
  endfunction

  task automatic chk_state(input string tag);
    int n = q.size();
    chk({tag, ".count"}, 32'(count), n);
    chk({tag, ".dec_level"}, 32'(dec_level), n_dec());
    chk({tag, ".empty"}, 32'(empty), (n == 0) ? 1 : 0);
    chk({tag, ".full"}, 32'(full), (n == DEPTH) ? 1 : 0);
    chk({tag, ".top_var"}, 32'(top_var), (n > 0) ? q[n-1].v : 0);
    chk({tag, ".top_val"}, 32'(top_val), (n > 0) ? q[n-1].val : 0);
    chk({tag, ".top_type"}, 32'(top_type), (n > 0) ? q[n-1].t : 0);
    chk({tag, ".overflow"}, 32'(overflow), ovf_m);
    chk({tag, ".underflow"}, 32'(underflow), unf_m);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask

  task automatic do_op(input bit p, input bit po, input int v, input int vl, input int t);
    ent_t e;
    e.v = v; e.val = vl; e.t = t;
    push = p; pop = po; var_in = VB'(v); val_in = vl[0]; type_in = t[0];
    tick();
    push = 0; pop = 0;
    if (p && po) begin
      if (q.size() > 0) q[q.size()-1] = e;
      else begin q.push_back(e); unf_m = 1; end
    end else if (p) begin
      if (q.size() == DEPTH) ovf_m = 1;
      else q.push_back(e);
    end else if (po) begin
      if (q.size() == 0) unf_m = 1;
      else void'(q.pop_back());
    end
  endtask

  task automatic model_clear();
    q.delete();
    ovf_m = 0;
    unf_m = 0;
  endtask

  // Unwind with uw_ready from a 4-cycle pattern (rnd=0) or random (rnd=1);
  // returns the number of cycles spent in UNWIND.
  task automatic run_bt(input string tag, input bit rnd, input bit [3:0] pat, output int cyc);
    ent_t ex[$];
    ent_t tmp[$];
    ent_t e;
    int   exp_found = 0, exp_var = 0, exp_val = 0;
    int   n0, k = 0;
    bit   done = 0;
    tmp = q;
    while (tmp.size() > 0) begin
      e = tmp.pop_back();
      ex.push_back(e);
      if (e.t == 0) begin
        exp_found = 1; exp_var = e.v; exp_val = e.val;
        break;
      end
    end
    n0 = q.size();
    backtrack = 1;
    tick();
    backtrack = 0;
    cyc = 0;
    while (!done && cyc < 100) begin
      uw_ready = rnd ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
      if (rnd) begin
        push = 1'($urandom_range(0, 1));
        pop  = 1'($urandom_range(0, 1));
        var_in = VB'($urandom_range(0, 127));
      end
      if (bt_done) begin
        done = 1;
      end else begin
        chk({tag, ".uw_valid"}, 32'(uw_valid), (n0 - k > 0) ? 1 : 0);
        if (uw_valid && uw_ready) begin
          if (k < ex.size()) begin
            chk({tag, ".uw_var"}, 32'(uw_var), ex[k].v);
            chk({tag, ".uw_val"}, 32'(uw_val), ex[k].val);
            chk({tag, ".uw_type"}, 32'(uw_type), ex[k].t);
          end else begin
            chk({tag, ".extra_beat"}, k, ex.size());
          end
          k++;
        end
        tick();
        cyc++;
      end
    end
    uw_ready = 0; push = 0; pop = 0;
    chk({tag, ".bt_done_seen"}, 32'(done), 1);
    chk({tag, ".beats"}, k, ex.size());
    chk({tag, ".bt_found"}, 32'(bt_found), exp_found);
    chk({tag, ".bt_var"}, 32'(bt_var), exp_var);
    chk({tag, ".bt_val"}, 32'(bt_val), exp_val);
    for (int i = 0; i < ex.size(); i++) void'(q.pop_back());
    tick();
    chk({tag, ".bt_done_pulse"}, 32'(bt_done), 0);
    chk({tag, ".bt_found_hold"}, 32'(bt_found), exp_found);
    chk({tag, ".bt_var_hold"}, 32'(bt_var), exp_var);
    chk_state({tag, ".after"});
  endtask

  initial begin
    int cyc;
    int r;

    // Reset values.
    tick(); tick();
    chk("rst.count", 32'(count), 0);
    chk("rst.dec_level", 32'(dec_level), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.uw_valid", 32'(uw_valid), 0);
    chk("rst.bt_done", 32'(bt_done), 0);
    chk("rst.bt_found", 32'(bt_found), 0);
    chk("rst.bt_var", 32'(bt_var), 0);
    chk("rst.bt_val", 32'(bt_val), 0);
    chk("rst.ovf", 32'(overflow), 0);
    chk("rst.unf", 32'(underflow), 0);
    chk("rst.top_var", 32'(top_var), 0);
    chk("rst.top_type", 32'(top_type), 0);
    reset = 0;
    tick();

    // Unwind stops at the most recent decision.
    do_op(1, 0, 5, 1, 1);
    do_op(1, 0, 9, 0, 0);
    do_op(1, 0, 3, 1, 1);
    do_op(1, 0, 7, 0, 1);
    chk_state("bt1.pre");
    run_bt("bt1", 0, 4'b1111, cyc);
    chk("bt1.count", 32'(count), 1);
    chk("bt1.dec_level", 32'(dec_level), 0);

    // Only forced entries: drains the stack, nothing found.
    do_op(0, 1, 0, 0, 0);
    do_op(1, 0, 11, 1, 1);
    do_op(1, 0, 12, 0, 1);
    do_op(1, 0, 13, 1, 1);
    run_bt("bt2", 0, 4'b1111, cyc);
    chk("bt2.empty", 32'(empty), 1);

    // Empty stack: DONE two cycles after backtrack.
    run_bt("bt_empty", 0, 4'b1111, cyc);
    chk("bt_empty.cycles", cyc, 1);

    // Fill, overflow, drain, underflow.
    for (int i = 0; i < DEPTH; i++) do_op(1, 0, 20 + i, i % 2, (i % 3 == 0) ? 0 : 1);
    chk_state("fill");
    do_op(1, 0, 99, 1, 0);
    chk_state("overflow");
    for (int i = 0; i < DEPTH; i++) do_op(0, 1, 0, 0, 0);
    do_op(0, 1, 0, 0, 0);
    chk_state("underflow");
    clear = 1; tick(); clear = 0; model_clear();
    chk_state("flags_clear");

    // Throttled uw_ready: 1,0,0,1.
    do_op(1, 0, 40, 1, 0);
    do_op(1, 0, 41, 0, 1);
    do_op(1, 0, 42, 1, 1);
    do_op(1, 0, 43, 0, 1);
    do_op(1, 0, 44, 1, 1);
    run_bt("bt_throttle", 0, 4'b1001, cyc);

    // Clear mid-unwind.
    do_op(1, 0, 50, 1, 0);
    do_op(1, 0, 51, 1, 1);
    do_op(1, 0, 52, 1, 1);
    backtrack = 1; tick(); backtrack = 0;
    uw_ready = 1; tick(); uw_ready = 0;
    clear = 1; tick(); clear = 0; model_clear();
    chk_state("clr_mid");
    for (int i = 0; i < 3; i++) begin
      chk("clr_mid.bt_done", 32'(bt_done), 0);
      tick();
    end

    // Reset mid-unwind.
    do_op(1, 0, 60, 0, 0);
    do_op(1, 0, 61, 1, 1);
    do_op(1, 0, 62, 1, 1);
    backtrack = 1; tick(); backtrack = 0;
    uw_ready = 1;
    reset = 1; #1;
    chk("rst_mid.busy", 32'(busy), 0);
    chk("rst_mid.count", 32'(count), 0);
    chk("rst_mid.uw_valid", 32'(uw_valid), 0);
    tick(); reset = 0; uw_ready = 0; model_clear();
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid.bt_done", 32'(bt_done), 0);
      tick();
    end
    chk_state("rst_mid");
    chk("rst_mid.bt_found", 32'(bt_found), 0);

    // Replace top: (4,1,D) -> (6,0,F).
    do_op(1, 0, 8, 0, 1);
    do_op(1, 0, 4, 1, 0);
    chk_state("repl.pre");
    do_op(1, 1, 6, 0, 1);
    chk_state("repl");
    chk("repl.dec_level", 32'(dec_level), 0);

    // Random traffic.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      do_op(1, 0, $urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 1));
      else if (r < 60) do_op(0, 1, 0, 0, 0);
      else if (r < 75) do_op(1, 1, $urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 1));
      else if (r < 87) run_bt("rnd_bt", 1, 4'b0000, cyc);
      else if (r < 90) begin clear = 1; tick(); clear = 0; model_clear(); end
      else tick();
      chk_state("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
